// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, checksummed program image over a valid/ready byte
// stream, writes it to instruction memory and holds the core in reset until the image is verified.
module imem_boot_loader #(
  parameter int DEPTH         = 256,
  parameter int ADDR_W        = 8,
  parameter int RELEASE_DELAY = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    DATA    = 3'd2,
    CSUM    = 3'd3,
    RELEASE = 3'd4,
    RUN     = 3'd5,
    ERROR   = 3'd6
  } state_t;

  localparam logic [8:0] DEPTH_W  = 9'(DEPTH);
  localparam logic [3:0] DLY_LAST = 4'(RELEASE_DELAY - 1);

  state_t     state, state_nx;
  logic [8:0] cnt, cnt_nx;
  logic [8:0] nlen, nlen_nx;
  logic [7:0] sum, sum_nx;
  logic [3:0] dly, dly_nx;
  logic [8:0] len_ext;
  logic       accept;
  logic       data_wr;

  // Next-state and datapath update for the load sequence
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    nlen_nx  = nlen;
    sum_nx   = sum;
    dly_nx   = dly;
    accept   = rx_valid & rx_ready;
    data_wr  = 1'b0;
    // a length byte of zero encodes a full 256-word image
    len_ext  = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
    case (state)
      IDLE: begin
        if (start) state_nx = LEN;
        else       state_nx = IDLE;
      end
      LEN: begin
        if (accept) begin
          if (len_ext > DEPTH_W) begin
            state_nx = ERROR;
          end else begin
            nlen_nx  = len_ext;
            cnt_nx   = 9'd0;
            sum_nx   = 8'd0;
            state_nx = DATA;
          end
        end else begin
          state_nx = LEN;
        end
      end
      DATA: begin
        if (accept) begin
          data_wr = 1'b1;
          sum_nx  = sum + rx_data;
          cnt_nx  = cnt + 9'd1;
          if (cnt == nlen - 9'd1) state_nx = CSUM;
          else                    state_nx = DATA;
        end else begin
          state_nx = DATA;
        end
      end
      CSUM: begin
        if (accept) begin
          if (rx_data == sum) begin
            dly_nx   = 4'd0;
            state_nx = RELEASE;
          end else begin
            state_nx = ERROR;
          end
        end else begin
          state_nx = CSUM;
        end
      end
      RELEASE: begin
        if (dly == DLY_LAST) begin
          state_nx = RUN;
        end else begin
          dly_nx   = dly + 4'd1;
          state_nx = RELEASE;
        end
      end
      RUN, ERROR: begin
        if (start) state_nx = LEN;
        else       state_nx = state;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, counters and registered outputs (outputs decoded from the next state)
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= IDLE;
      cnt        <= 9'd0;
      nlen       <= 9'd0;
      sum        <= 8'd0;
      dly        <= 4'd0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 8'd0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      nlen     <= nlen_nx;
      sum      <= sum_nx;
      dly      <= dly_nx;
      rx_ready <= (state_nx == LEN) || (state_nx == DATA) || (state_nx == CSUM);
      busy     <= (state_nx == LEN) || (state_nx == DATA) || (state_nx == CSUM) ||
                  (state_nx == RELEASE);
      done     <= (state_nx == RUN);
      error    <= (state_nx == ERROR);
      cpu_hold <= (state_nx != RUN);
      imem_we  <= data_wr;
      if (data_wr) begin
        imem_addr  <= cnt[ADDR_W-1:0];
        imem_wdata <= rx_data;
      end else begin
        imem_addr  <= imem_addr;
        imem_wdata <= imem_wdata;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: table frames, randomized frames against a frame-level
// model, and hand-written corner cases (full image, oversize length, reset mid-load).
module tb_imem_boot_loader;
  localparam int RD = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       start = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_ready, imem_we, cpu_hold, busy, done, error;
  logic [7:0] imem_addr, imem_wdata;

  logic       s_start = 1'b0;
  logic       s_rx_valid = 1'b0;
  logic [7:0] s_rx_data = 8'd0;
  logic       s_rx_ready, s_imem_we, s_cpu_hold, s_busy, s_done, s_error;
  logic [1:0] s_imem_addr;
  logic [7:0] s_imem_wdata;

  imem_boot_loader #(.DEPTH(256), .ADDR_W(8), .RELEASE_DELAY(RD)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error));

  imem_boot_loader #(.DEPTH(4), .ADDR_W(2), .RELEASE_DELAY(RD)) dut_small (
    .Clk(Clk), .Reset(Reset), .start(s_start), .rx_data(s_rx_data), .rx_valid(s_rx_valid),
    .rx_ready(s_rx_ready), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
    .imem_wdata(s_imem_wdata), .cpu_hold(s_cpu_hold), .busy(s_busy), .done(s_done),
    .error(s_error));

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_count = 0;
  int s_wr_count = 0;
  logic [7:0] shadow [0:255];
  logic [7:0] frame_q [$];

  always @(posedge Clk) begin
    if (imem_we) begin
      shadow[imem_addr] <= imem_wdata;
      wr_count <= wr_count + 1;
    end
    if (s_imem_we) s_wr_count <= s_wr_count + 1;
  end

  typedef struct {
    logic [47:0] bytes;
    int          nb;
    int          gap;
    logic        exp_err;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ready", rx_ready, 1);
    chk("start_error", error, 0);
    chk("start_done", done, 0);
    chk("start_hold", cpu_hold, 1);
  endtask

  // Offer one byte after a random gap; returns once the byte has been accepted
  task automatic send_byte(input logic [7:0] b, input int maxgap, input bit noise);
    int gaps;
    int guard;
    logic r;
    gaps = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    for (int g = 0; g < gaps; g++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    start    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    guard    = 0;
    forever begin
      r = rx_ready;
      tick();
      if (r) break;
      guard++;
      if (guard > 50) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Frame-level reference: N'=(N==0)?256:N words, sum mod 256 decides release vs error
  task automatic run_frame(input int maxgap, input bit noise);
    int n;
    int w0;
    int bad_mem;
    logic [7:0] exp_sum;
    logic [7:0] b;
    n = (frame_q[0] == 8'd0) ? 256 : int'(frame_q[0]);
    pulse_start();
    w0 = wr_count;
    send_byte(frame_q[0], maxgap, noise);
    exp_sum = 8'd0;
    for (int i = 0; i < n; i++) begin
      b = frame_q[1 + i];
      send_byte(b, maxgap, noise);
      chk("wr_we", imem_we, 1);
      chk("wr_addr", imem_addr, i & 255);
      chk("wr_data", imem_wdata, b);
      exp_sum = exp_sum + b;
    end
    send_byte(frame_q[n + 1], maxgap, noise);
    chk("csum_we_after", imem_we, 0);
    if (frame_q[n + 1] == exp_sum) begin
      repeat (RD - 1) tick();
      chk("release_hold", cpu_hold, 1);
      chk("release_busy", busy, 1);
      tick();
      chk("run_hold", cpu_hold, 0);
      chk("run_done", done, 1);
      chk("run_busy", busy, 0);
    end else begin
      chk("err_flag", error, 1);
      chk("err_hold", cpu_hold, 1);
      chk("err_ready", rx_ready, 0);
      chk("err_busy", busy, 0);
    end
    tick();
    chk("write_count", wr_count - w0, n);
    bad_mem = 0;
    for (int i = 0; i < n; i++) begin
      if (shadow[i] !== frame_q[1 + i]) bad_mem++;
    end
    chk("mem_contents", bad_mem, 0);
  endtask

  task automatic s_send(input logic [7:0] b);
    int guard;
    logic r;
    s_rx_valid = 1'b1;
    s_rx_data  = b;
    guard      = 0;
    forever begin
      r = s_rx_ready;
      tick();
      if (r) break;
      guard++;
      if (guard > 50) begin
        chk("s_accept_timeout", 0, 1);
        break;
      end
    end
    s_rx_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] s;
    tbl[0] = '{48'h03_40_48_81_09_00, 5, 0, 1'b0};
    tbl[1] = '{48'h03_40_48_81_0A_00, 5, 0, 1'b1};
    tbl[2] = '{48'h03_40_48_81_09_00, 5, 3, 1'b0};
    tbl[3] = '{48'h01_C0_C0_00_00_00, 3, 2, 1'b0};
    tbl[4] = '{48'h02_FF_02_01_00_00, 4, 1, 1'b0};
    tbl[5] = '{48'h01_C0_C1_00_00_00, 3, 0, 1'b1};

    Reset = 1'b0;
    repeat (2) tick();
    chk("rst_hold", cpu_hold, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_ready", rx_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    Reset = 1'b1;
    tick();

    // rx_valid in IDLE must be ignored
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (3) tick();
    rx_valid = 1'b0;
    chk("idle_no_write", wr_count, 0);
    chk("idle_busy", busy, 0);

    for (int t = 0; t < 6; t++) begin
      frame_q.delete();
      for (int k = 0; k < tbl[t].nb; k++) frame_q.push_back(tbl[t].bytes[47 - 8*k -: 8]);
      run_frame(tbl[t].gap, 1'b0);
      chk("tbl_error", error, tbl[t].exp_err);
      chk("tbl_done", done, !tbl[t].exp_err);
      chk("tbl_hold", cpu_hold, tbl[t].exp_err);
      if (t == 0) begin
        n = wr_count;
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (3) tick();
        rx_valid = 1'b0;
        chk("run_ignore_rx", wr_count, n);
        chk("run_stays_done", done, 1);
      end
    end

    // randomized frames, start toggling while busy must be ignored
    for (int r = 0; r < 20; r++) begin
      frame_q.delete();
      n = $urandom_range(1, 12);
      frame_q.push_back(8'(n));
      s = 8'd0;
      for (int k = 0; k < n; k++) begin
        frame_q.push_back(8'($urandom));
        s = s + frame_q[k + 1];
      end
      if ($urandom_range(0, 3) == 0) s = s + 8'($urandom_range(1, 255));
      frame_q.push_back(s);
      run_frame(3, 1'b1);
    end

    // full 256-word image
    frame_q.delete();
    frame_q.push_back(8'h00);
    for (int k = 0; k < 256; k++) frame_q.push_back(8'(k));
    frame_q.push_back(8'h80);
    run_frame(0, 1'b0);
    chk("full_done", done, 1);
    chk("full_last_addr", imem_addr, 8'hFF);

    // reset after two data bytes aborts the load
    pulse_start();
    send_byte(8'h03, 0, 1'b0);
    send_byte(8'h40, 0, 1'b0);
    send_byte(8'h48, 0, 1'b0);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    chk("abort_hold", cpu_hold, 1);
    chk("abort_busy", busy, 0);
    chk("abort_we", imem_we, 0);
    chk("abort_ready", rx_ready, 0);
    chk("abort_kept_mem", shadow[1], 8'h48);
    tick();
    frame_q.delete();
    frame_q.push_back(8'h01);
    frame_q.push_back(8'hC0);
    frame_q.push_back(8'hC0);
    run_frame(0, 1'b0);
    chk("abort_new_done", done, 1);

    // DEPTH=4 instance: oversize length errors immediately, N'==DEPTH accepted
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_send(8'h05);
    chk("small_err", s_error, 1);
    chk("small_hold", s_cpu_hold, 1);
    chk("small_ready", s_rx_ready, 0);
    chk("small_busy", s_busy, 0);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("small_err_cleared", s_error, 0);
    s_send(8'h04);
    chk("small_len4_ready", s_rx_ready, 1);
    chk("small_len4_err", s_error, 0);
    chk("small_no_we", s_wr_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
